// File: rtl/paint_engine_if.sv
// Command and pixel-write bus for the rectangle paint engine.
// The master issues drawing commands and receives the framebuffer write stream;
// the slave (the engine) accepts commands and produces the writes.
`timescale 1ns/1ps
interface paint_engine_if #(
    parameter int COORD_W   = 11,
    parameter int PALETTE_W = 2
) ();

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_mode;
    logic [COORD_W-1:0]   cmd_x0;
    logic [COORD_W-1:0]   cmd_y0;
    logic [COORD_W-1:0]   cmd_x1;
    logic [COORD_W-1:0]   cmd_y1;
    logic [PALETTE_W-1:0] cmd_palette;

    logic [COORD_W-1:0]   write_x;
    logic [COORD_W-1:0]   write_y;
    logic [PALETTE_W-1:0] write_palette;
    logic                 write_en;
    logic                 busy;
    logic                 done;

    modport master (
        output cmd_valid,
        output cmd_mode,
        output cmd_x0,
        output cmd_y0,
        output cmd_x1,
        output cmd_y1,
        output cmd_palette,
        input  cmd_ready,
        input  write_x,
        input  write_y,
        input  write_palette,
        input  write_en,
        input  busy,
        input  done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_mode,
        input  cmd_x0,
        input  cmd_y0,
        input  cmd_x1,
        input  cmd_y1,
        input  cmd_palette,
        output cmd_ready,
        output write_x,
        output write_y,
        output write_palette,
        output write_en,
        output busy,
        output done
    );

endinterface

// File: rtl/paint_engine.sv
// Rectangle paint engine: takes CLEAR / FILL / OUTLINE / NOP commands and emits
// one framebuffer pixel visit per cycle in raster order. Corners are sorted and
// clamped at acceptance; rectangles lying fully off-screen collapse into a NOP.
// The interface instance must use the same COORD_W and PALETTE_W as this module.
`timescale 1ns/1ps
module paint_engine #(
    parameter int SCREEN_W  = 800,
    parameter int SCREEN_H  = 600,
    parameter int COORD_W   = 11,
    parameter int PALETTE_W = 2
) (
    input  logic          clk_33m,
    input  logic          rst,
    paint_engine_if.slave bus
);

    localparam logic [COORD_W-1:0] MAX_X = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(SCREEN_H - 1);
    localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    typedef enum logic [1:0] {
        MODE_CLEAR   = 2'd0,
        MODE_FILL    = 2'd1,
        MODE_OUTLINE = 2'd2,
        MODE_NOP     = 2'd3
    } mode_t;

    state_t               r_state;
    state_t               w_state_next;

    logic                 r_alive;
    logic [COORD_W-1:0]   r_xa;
    logic [COORD_W-1:0]   r_xb;
    logic [COORD_W-1:0]   r_ya;
    logic [COORD_W-1:0]   r_yb;
    logic [COORD_W-1:0]   r_cx;
    logic [COORD_W-1:0]   r_cy;
    logic                 r_outline;
    logic [PALETTE_W-1:0] r_palette;

    logic [COORD_W-1:0]   r_wr_x;
    logic [COORD_W-1:0]   r_wr_y;
    logic [PALETTE_W-1:0] r_wr_palette;
    logic                 r_wr_en;
    logic                 r_done;

    mode_t                w_mode;
    logic [COORD_W-1:0]   w_sx_lo;
    logic [COORD_W-1:0]   w_sx_hi;
    logic [COORD_W-1:0]   w_sy_lo;
    logic [COORD_W-1:0]   w_sy_hi;
    logic [COORD_W-1:0]   w_xa;
    logic [COORD_W-1:0]   w_xb;
    logic [COORD_W-1:0]   w_ya;
    logic [COORD_W-1:0]   w_yb;
    logic                 w_cmd_nop;

    logic                 w_ready;
    logic                 w_last;
    logic                 w_load;
    logic                 w_step;
    logic                 w_finish;
    logic                 w_nop_done;

    logic [COORD_W-1:0]   w_nx;
    logic [COORD_W-1:0]   w_ny;
    logic                 w_on_edge;

    // cmd_ready stays low through reset and the first edge after it
    assign w_ready = (r_state == ST_IDLE) && r_alive;

    assign bus.cmd_ready     = w_ready;
    assign bus.busy          = (r_state == ST_RUN);
    assign bus.done          = r_done;
    assign bus.write_en      = r_wr_en;
    assign bus.write_x       = r_wr_x;
    assign bus.write_y       = r_wr_y;
    assign bus.write_palette = r_wr_palette;

    // Sort and clamp the incoming corners; CLEAR overrides them with the full screen
    always_comb begin
        w_mode    = mode_t'(bus.cmd_mode);
        w_sx_lo   = (bus.cmd_x0 < bus.cmd_x1) ? bus.cmd_x0 : bus.cmd_x1;
        w_sx_hi   = (bus.cmd_x0 < bus.cmd_x1) ? bus.cmd_x1 : bus.cmd_x0;
        w_sy_lo   = (bus.cmd_y0 < bus.cmd_y1) ? bus.cmd_y0 : bus.cmd_y1;
        w_sy_hi   = (bus.cmd_y0 < bus.cmd_y1) ? bus.cmd_y1 : bus.cmd_y0;
        w_xa      = w_sx_lo;
        w_ya      = w_sy_lo;
        w_xb      = (w_sx_hi > MAX_X) ? MAX_X : w_sx_hi;
        w_yb      = (w_sy_hi > MAX_Y) ? MAX_Y : w_sy_hi;
        w_cmd_nop = (w_mode == MODE_NOP) || (w_xa > MAX_X) || (w_ya > MAX_Y);
        if (w_mode == MODE_CLEAR) begin
            w_xa      = '0;
            w_ya      = '0;
            w_xb      = MAX_X;
            w_yb      = MAX_Y;
            w_cmd_nop = 1'b0;
        end
    end

    // Next-state decode: accept in IDLE, scan in RUN until the bottom-right corner
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_nop_done   = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        w_last       = (r_cx == r_xb) && (r_cy == r_yb);
        case (r_state)
            ST_IDLE: begin
                if (w_ready && bus.cmd_valid) begin
                    if (w_cmd_nop) begin
                        w_nop_done = 1'b1;
                    end else begin
                        w_load       = 1'b1;
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Raster step: wrap to xa on the next row, and flag pixels on the outline border
    always_comb begin
        if (r_cx == r_xb) begin
            w_nx = r_xa;
            w_ny = r_cy + ONE;
        end else begin
            w_nx = r_cx + ONE;
            w_ny = r_cy;
        end
        w_on_edge = (w_nx == r_xa) || (w_nx == r_xb) || (w_ny == r_ya) || (w_ny == r_yb);
    end

    // State register
    always_ff @(posedge clk_33m) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command capture, scan counters and the registered write port
    always_ff @(posedge clk_33m) begin
        if (rst) begin
            r_alive      <= 1'b0;
            r_xa         <= '0;
            r_xb         <= '0;
            r_ya         <= '0;
            r_yb         <= '0;
            r_cx         <= '0;
            r_cy         <= '0;
            r_outline    <= 1'b0;
            r_palette    <= '0;
            r_wr_x       <= '0;
            r_wr_y       <= '0;
            r_wr_palette <= '0;
            r_wr_en      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            r_wr_en <= 1'b0;
            r_done  <= w_nop_done || w_finish;
            if (w_load) begin
                r_xa         <= w_xa;
                r_xb         <= w_xb;
                r_ya         <= w_ya;
                r_yb         <= w_yb;
                r_cx         <= w_xa;
                r_cy         <= w_ya;
                r_outline    <= (w_mode == MODE_OUTLINE);
                r_palette    <= bus.cmd_palette;
                r_wr_x       <= w_xa;
                r_wr_y       <= w_ya;
                r_wr_palette <= bus.cmd_palette;
                r_wr_en      <= 1'b1;
            end
            if (w_step) begin
                r_cx <= w_nx;
                r_cy <= w_ny;
                if (!r_outline || w_on_edge) begin
                    r_wr_x       <= w_nx;
                    r_wr_y       <= w_ny;
                    r_wr_palette <= r_palette;
                    r_wr_en      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_paint_engine.sv
// Self-checking bench for paint_engine on an 8x4 screen.
// A reference model pushes every expected pixel write and done pulse (with its
// cycle number) into queues as each command is driven; a monitor pops and
// compares them as the engine produces output.
`timescale 1ns/1ps
module tb_paint_engine;

    localparam int SW = 8;
    localparam int SH = 4;
    localparam int CW = 11;
    localparam int PW = 2;

    typedef struct {
        int cyc;
        int x;
        int y;
        int pal;
    } wr_t;

    logic clk_33m = 1'b0;
    logic rst     = 1'b1;

    paint_engine_if #(.COORD_W(CW), .PALETTE_W(PW)) bus ();

    paint_engine #(
        .SCREEN_W (SW),
        .SCREEN_H (SH),
        .COORD_W  (CW),
        .PALETTE_W(PW)
    ) dut (
        .clk_33m(clk_33m),
        .rst    (rst),
        .bus    (bus.slave)
    );

    wr_t wrQ[$];
    int  doneQ[$];
    int  cyc        = 0;
    int  errors     = 0;
    int  checks     = 0;
    bit  rstSampled = 1'b1;
    int  lastX      = 0;
    int  lastY      = 0;
    int  lastPal    = 0;
    wr_t e;
    int  ed;

    // Roughly 33 MHz clock
    always #15 clk_33m = ~clk_33m;

    // Cycle counter and reset tracker, advanced on every active edge
    always @(posedge clk_33m) begin
        cyc        <= cyc + 1;
        rstSampled <= rst;
    end

    // Output monitor: compare writes and done pulses against the scoreboard
    always @(negedge clk_33m) begin
        if (rstSampled) begin
            lastX   = 0;
            lastY   = 0;
            lastPal = 0;
        end else begin
            if (bus.write_en === 1'b1) begin
                checks++;
                if (wrQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write cyc=%0d got (%0d,%0d) pal=%0d, required no write",
                             cyc, bus.write_x, bus.write_y, bus.write_palette);
                end else begin
                    e = wrQ.pop_front();
                    if (cyc != e.cyc || bus.write_x !== CW'(e.x) || bus.write_y !== CW'(e.y) ||
                        bus.write_palette !== PW'(e.pal)) begin
                        errors++;
                        $display("[TB] FAIL write_pixel got cyc=%0d (%0d,%0d) pal=%0d, required cyc=%0d (%0d,%0d) pal=%0d",
                                 cyc, bus.write_x, bus.write_y, bus.write_palette, e.cyc, e.x, e.y, e.pal);
                    end
                    lastX   = e.x;
                    lastY   = e.y;
                    lastPal = e.pal;
                end
            end else begin
                checks++;
                if (bus.write_en !== 1'b0 || bus.write_x !== CW'(lastX) || bus.write_y !== CW'(lastY) ||
                    bus.write_palette !== PW'(lastPal)) begin
                    errors++;
                    $display("[TB] FAIL hold_value cyc=%0d got en=%b (%0d,%0d) pal=%0d, required en=0 (%0d,%0d) pal=%0d",
                             cyc, bus.write_en, bus.write_x, bus.write_y, bus.write_palette, lastX, lastY, lastPal);
                end
            end
            if (bus.done === 1'b1) begin
                checks++;
                if (doneQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_done cyc=%0d, required no done", cyc);
                end else begin
                    ed = doneQ.pop_front();
                    if (cyc != ed) begin
                        errors++;
                        $display("[TB] FAIL done_timing got cyc=%0d, required cyc=%0d", cyc, ed);
                    end
                end
                checks++;
                if (bus.write_en !== 1'b0 || bus.cmd_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL done_cycle got write_en=%b cmd_ready=%b, required write_en=0 cmd_ready=1",
                             bus.write_en, bus.cmd_ready);
                end
            end
        end
    end

    // Reference model: push the expected writes and done pulse for a command accepted in cycle t
    task automatic pushExpected(input int mode, input int x0, input int y0, input int x1, input int y1,
                                input int pal, input int t, input int limit, input bit withDone);
        int xa, xb, ya, yb, k;
        bit nop;
        if (mode == 0) begin
            xa = 0; ya = 0; xb = SW - 1; yb = SH - 1;
        end else begin
            xa = (x0 < x1) ? x0 : x1;
            xb = (x0 < x1) ? x1 : x0;
            ya = (y0 < y1) ? y0 : y1;
            yb = (y0 < y1) ? y1 : y0;
            if (xb > SW - 1) xb = SW - 1;
            if (yb > SH - 1) yb = SH - 1;
        end
        nop = (mode == 3) || (mode != 0 && (xa > SW - 1 || ya > SH - 1));
        if (nop) begin
            if (withDone) doneQ.push_back(t + 1);
        end else begin
            k = 0;
            for (int y = ya; y <= yb; y++) begin
                for (int x = xa; x <= xb; x++) begin
                    k++;
                    if ((limit < 0 || k <= limit) &&
                        (mode != 2 || x == xa || x == xb || y == ya || y == yb))
                        wrQ.push_back('{t + k, x, y, pal});
                end
            end
            if (withDone) doneQ.push_back(t + k + 1);
        end
    endtask

    // Present one command at the first ready cycle and record its expectations
    task automatic applyStimulus(input int mode, input int x0, input int y0, input int x1, input int y1,
                                 input int pal, input int limit, input bit withDone, output int t);
        int waited;
        waited = 0;
        @(negedge clk_33m);
        while (bus.cmd_ready !== 1'b1 && waited < 200) begin
            @(negedge clk_33m);
            waited++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            checks++;
            $display("[TB] FAIL ready_timeout got cmd_ready=%b, required 1 within 200 cycles", bus.cmd_ready);
            t = -1;
        end else begin
            bus.cmd_valid   = 1'b1;
            bus.cmd_mode    = 2'(mode);
            bus.cmd_x0      = CW'(x0);
            bus.cmd_y0      = CW'(y0);
            bus.cmd_x1      = CW'(x1);
            bus.cmd_y1      = CW'(y1);
            bus.cmd_palette = PW'(pal);
            t = cyc;
            pushExpected(mode, x0, y0, x1, y1, pal, t, limit, withDone);
            @(posedge clk_33m);
            #1;
            bus.cmd_valid = 1'b0;
        end
    endtask

    // Wait until every expected event has been seen
    task automatic waitDrain(input string name);
        int waited;
        waited = 0;
        while ((wrQ.size() != 0 || doneQ.size() != 0) && waited < 300) begin
            @(negedge clk_33m);
            waited++;
        end
        @(negedge clk_33m);
        checks++;
        if (wrQ.size() != 0 || doneQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_%s got %0d writes and %0d dones outstanding, required 0 and 0",
                     name, wrQ.size(), doneQ.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_33m);
        checks++;
        if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.write_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got ready=%b busy=%b done=%b en=%b, required all 0",
                     bus.cmd_ready, bus.busy, bus.done, bus.write_en);
        end
        checks++;
        if (bus.write_x !== '0 || bus.write_y !== '0 || bus.write_palette !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data got (%0d,%0d) pal=%0d, required (0,0) pal=0",
                     bus.write_x, bus.write_y, bus.write_palette);
        end
        rst = 1'b0;
        @(negedge clk_33m);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready got %b, required 1", bus.cmd_ready);
        end
    endtask

    task automatic test_fill();
        int t;
        applyStimulus(1, 1, 1, 3, 2, 2, -1, 1'b1, t);
        @(negedge clk_33m);
        checks++;
        if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_busy got busy=%b ready=%b, required busy=1 ready=0", bus.busy, bus.cmd_ready);
        end
        waitDrain("fill");
    endtask

    task automatic test_outline();
        int t;
        applyStimulus(2, 5, 3, 3, 0, 3, -1, 1'b1, t);
        waitDrain("outline");
        applyStimulus(2, 4, 2, 4, 2, 1, -1, 1'b1, t);
        waitDrain("outline_pixel");
        applyStimulus(2, 0, 3, 7, 3, 2, -1, 1'b1, t);
        waitDrain("outline_row");
        applyStimulus(2, 2, 3, 2, 0, 1, -1, 1'b1, t);
        waitDrain("outline_column");
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        applyStimulus(0, 5, 5, 5, 5, 1, -1, 1'b1, t1);
        applyStimulus(1, 0, 0, 1, 0, 3, -1, 1'b1, t2);
        checks++;
        if (t2 != t1 + 33) begin
            errors++;
            $display("[TB] FAIL back_to_back_accept got cyc=%0d, required cyc=%0d", t2, t1 + 33);
        end
        waitDrain("back_to_back");
    endtask

    task automatic test_clamp_nop();
        int t;
        applyStimulus(1, 6, 2, 20, 9, 2, -1, 1'b1, t);
        waitDrain("clamp");
        applyStimulus(1, 9, 0, 12, 1, 1, -1, 1'b1, t);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nop_ready got ready=%b busy=%b, required ready=1 busy=0", bus.cmd_ready, bus.busy);
        end
        waitDrain("degenerate_nop");
        applyStimulus(3, 1, 1, 2, 2, 3, -1, 1'b1, t);
        waitDrain("mode_nop");
    endtask

    task automatic test_ignore_busy();
        int t;
        applyStimulus(1, 0, 0, 7, 1, 1, -1, 1'b1, t);
        bus.cmd_valid   = 1'b1;
        bus.cmd_mode    = 2'd0;
        bus.cmd_palette = PW'(3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_33m);
            checks++;
            if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL busy_ignore got ready=%b busy=%b, required ready=0 busy=1",
                         bus.cmd_ready, bus.busy);
            end
        end
        bus.cmd_valid = 1'b0;
        waitDrain("ignore_busy");
    endtask

    task automatic test_reset_abort();
        int t;
        int waited;
        applyStimulus(0, 0, 0, 0, 0, 2, 4, 1'b0, t);
        waited = 0;
        while (cyc < t + 4 && waited < 20) begin
            @(negedge clk_33m);
            waited++;
        end
        rst = 1'b1;
        @(negedge clk_33m);
        checks++;
        if (bus.write_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_state got en=%b busy=%b done=%b ready=%b, required all 0",
                     bus.write_en, bus.busy, bus.done, bus.cmd_ready);
        end
        rst = 1'b0;
        @(negedge clk_33m);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_ready got %b, required 1", bus.cmd_ready);
        end
        repeat (40) @(negedge clk_33m);
        waitDrain("abort");
    endtask

    // Run every scenario in sequence, then report
    initial begin
        bus.cmd_valid   = 1'b0;
        bus.cmd_mode    = 2'd3;
        bus.cmd_x0      = '0;
        bus.cmd_y0      = '0;
        bus.cmd_x1      = '0;
        bus.cmd_y1      = '0;
        bus.cmd_palette = '0;
        test_reset();
        test_fill();
        test_outline();
        test_back_to_back();
        test_clamp_nop();
        test_ignore_busy();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got no finish, required finish within 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
